// File: rtl/keyed_product_store.sv
// keyed_product_store: shift-and-add key multiplier writing into a 16-word register file
// addressed through a one-hot decoder, with registered write-through readback.
module keyed_product_store #(
    parameter int OP_W   = 4,
    parameter int ADDR_W = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   we_i,
    input  logic [OP_W-1:0]        num_rot_i,
    input  logic [OP_W-1:0]        key_i,
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [(2**ADDR_W)-1:0] word_sel_o,
    output logic [2*OP_W-1:0]      product_o,
    output logic [2*OP_W-1:0]      stored_value_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int P_W   = 2*OP_W;

    logic [P_W-1:0] mem_q [DEPTH];
    logic [P_W-1:0] mem_d [DEPTH];
    logic [P_W-1:0] stored_value_q, stored_value_d;
    logic [P_W-1:0] prod;
    logic [P_W-1:0] rd_data;
    logic [DEPTH-1:0] sel;

    assign sel = {{(DEPTH-1){1'b0}}, 1'b1} << addr_i;

    always_comb begin
        prod = '0;
        for (int i = 0; i < OP_W; i++)
            prod = prod + (key_i[i] ? ({{OP_W{1'b0}}, num_rot_i} << i) : '0);
    end

    // One-hot AND-OR read mux driven by the decoder rather than a binary index.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < DEPTH; k++)
            rd_data = rd_data | (sel[k] ? mem_q[k] : '0);
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++)
            mem_d[k] = (we_i && sel[k]) ? prod : mem_q[k];
        stored_value_d = we_i ? prod : rd_data;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < DEPTH; k++)
                mem_q[k] <= '0;
            stored_value_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                mem_q[k] <= mem_d[k];
            stored_value_q <= stored_value_d;
        end
    end

    assign word_sel_o     = sel;
    assign product_o      = prod;
    assign stored_value_o = stored_value_q;
endmodule

// File: tb/tb_keyed_product_store.sv
// tb_keyed_product_store: directed spec scenarios plus randomized traffic checked
// against an array-based memory model.
module tb_keyed_product_store;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  num_rot = '0;
    logic [3:0]  key = '0;
    logic [3:0]  addr = '0;
    logic [15:0] word_sel;
    logic [7:0]  product;
    logic [7:0]  stored_value;

    int tests = 0;
    int errs = 0;
    int ref_mem [16];
    int ref_sv = 0;

    keyed_product_store dut (
        .clock_i(clk),
        .reset_n_i(reset_n),
        .we_i(we),
        .num_rot_i(num_rot),
        .key_i(key),
        .addr_i(addr),
        .word_sel_o(word_sel),
        .product_o(product),
        .stored_value_o(stored_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rn, input logic w, input logic [3:0] nr, input logic [3:0] k,
                        input logic [3:0] a);
        int p;
        reset_n = rn;
        we = w;
        num_rot = nr;
        key = k;
        addr = a;
        p = int'(nr) * int'(k);
        #1;
        check("product", {8'h00, product}, 16'(p));
        check("word_sel", word_sel, 16'(1 << a));
        @(posedge clk);
        #1;
        if (!rn) begin
            foreach (ref_mem[i]) ref_mem[i] = 0;
            ref_sv = 0;
        end else if (w) begin
            ref_mem[a] = p;
            ref_sv = p;
        end else begin
            ref_sv = ref_mem[a];
        end
        check("stored_value", {8'h00, stored_value}, 16'(ref_sv));
    endtask

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 0;
        step(1'b0, 1'b1, 4'd9, 4'd9, 4'd0);
        check("reset_sv", {8'h00, stored_value}, 16'd0);
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'(a));
        step(1'b1, 1'b1, 4'd3, 4'd5, 4'd2);
        check("t2_write", {8'h00, stored_value}, 16'd15);
        step(1'b1, 1'b1, 4'd15, 4'd15, 4'd15);
        check("t3_write", {8'h00, stored_value}, 16'h00e1);
        step(1'b1, 1'b0, 4'd1, 4'd1, 4'd2);
        check("t4_rd2", {8'h00, stored_value}, 16'd15);
        step(1'b1, 1'b0, 4'd1, 4'd1, 4'd15);
        check("t4_rd15", {8'h00, stored_value}, 16'h00e1);
        step(1'b1, 1'b0, 4'd1, 4'd1, 4'd9);
        check("t4_rd9", {8'h00, stored_value}, 16'd0);
        step(1'b1, 1'b1, 4'd6, 4'd0, 4'd2);
        check("t5_zero", {8'h00, stored_value}, 16'd0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 4'd15);
        check("t5_hold15", {8'h00, stored_value}, 16'h00e1);
        step(1'b1, 1'b1, 4'd2, 4'd3, 4'd4);
        step(1'b0, 1'b1, 4'd7, 4'd7, 4'd4);
        check("t6_rst_sv", {8'h00, stored_value}, 16'd0);
        step(1'b1, 1'b0, 4'd0, 4'd0, 4'd4);
        check("t6_word4", {8'h00, stored_value}, 16'd0);
        step(1'b1, 1'b1, 4'd5, 4'd5, 4'd7);
        step(1'b1, 1'b1, 4'd4, 4'd4, 4'd7);
        step(1'b1, 1'b0, 4'd0, 4'd0, 4'd7);
        check("last_wins", {8'h00, stored_value}, 16'd16);
        for (int n = 0; n < 500; n++)
            step($urandom_range(0, 59) != 0, 1'($urandom), 4'($urandom), 4'($urandom),
                 4'($urandom_range(0, 15)));
        for (int a = 0; a < 16; a++) step(1'b1, 1'b0, 4'd0, 4'd0, 4'(a));
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
